// File: rtl/sequenciador_mostra_leds.sv
// Plays back the stored move sequence on the LEDs, one timed flash per entry up to the latched round.
// Optional macro ACELERA_EN shortens the on-time per round, clamped at TEMPO_MIN.
`timescale 1ns/1ps
module sequenciador_mostra_leds #(
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 16,
  parameter int TEMPO_ON  = 500,
  parameter int TEMPO_OFF = 250,
  parameter int PASSO     = 25,
  parameter int TEMPO_MIN = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              mostrando,
  output logic              fim,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam logic [CNT_W-1:0] UM    = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_OFF = CNT_W'(TEMPO_OFF);

  if (TEMPO_ON < 1 || TEMPO_OFF < 1 || TEMPO_MIN < 1 || PASSO < 0 || TEMPO_ON >= 2**CNT_W) begin : g_cfg_invalid
    $error("sequenciador_mostra_leds: invalid timing parameters");
  end

  estado_t           estado_q, estado_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic [CNT_W-1:0]  t_on;

`ifdef ACELERA_EN
  logic [CNT_W-1:0] ton_q, ton_d, ton_calc;
  logic [31:0]      reducao;

  // Subtraction only happens once the reduction is known to be smaller than TEMPO_ON.
  always_comb begin
    reducao = 32'(rodada) * 32'(PASSO);
    if (reducao >= 32'(TEMPO_ON) || (32'(TEMPO_ON) - reducao) < 32'(TEMPO_MIN))
      ton_calc = CNT_W'(TEMPO_MIN);
    else
      ton_calc = CNT_W'(32'(TEMPO_ON) - reducao);
  end

  assign ton_d = (estado_q == OCIOSO && iniciar) ? ton_calc : ton_q;
  assign t_on  = ton_q;

  always_ff @(posedge clock) begin
    if (reset) ton_q <= CNT_W'(TEMPO_ON);
    else       ton_q <= ton_d;
  end
`else
  assign t_on = CNT_W'(TEMPO_ON);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      timer_q  <= '0;
      end_q    <= '0;
      rodada_q <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      end_q    <= end_d;
      rodada_q <= rodada_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    end_d    = end_q;
    rodada_d = rodada_q;
    if (estado_q != OCIOSO && abortar) begin
      estado_d = OCIOSO;
      timer_d  = '0;
      end_d    = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          end_d = '0;
          if (iniciar) begin
            rodada_d = rodada;
            timer_d  = '0;
            estado_d = CARREGA;
          end
        end
        CARREGA: begin
          timer_d  = '0;
          estado_d = ACESO;
        end
        ACESO: begin
          if (timer_q == t_on - UM) begin
            timer_d  = '0;
            estado_d = APAGADO;
          end else begin
            timer_d = timer_q + UM;
          end
        end
        APAGADO: begin
          if (timer_q == T_OFF - UM) begin
            timer_d  = '0;
            estado_d = (end_q == rodada_q) ? FIM : PROXIMO;
          end else begin
            timer_d = timer_q + UM;
          end
        end
        PROXIMO: begin
          end_d    = end_q + 1'b1;
          estado_d = CARREGA;
        end
        FIM: begin
          end_d    = '0;
          estado_d = OCIOSO;
        end
        default: begin
          timer_d  = '0;
          end_d    = '0;
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  always_comb begin
    leds      = (estado_q == ACESO) ? dado_mem : 4'b0000;
    mostrando = (estado_q != OCIOSO);
    fim       = (estado_q == FIM);
    db_estado = estado_q;
    endereco  = end_q;
  end

endmodule

// File: doc/sequenciador_mostra_leds.md
Name: sequenciador_mostra_leds

Overview:
Controller that plays back the stored move sequence on the LEDs before each round of the memory game. On a start pulse it walks the sequence memory from address 0 up to the current round index. For each entry it holds the LED pattern on for a fixed time, then off for a gap. It then signals completion to the game control unit. It drives the memory address and the LED-display path, and replaces ad-hoc single-LED display logic at the top level.

Parameters:
ADDR_W, 4, width of memory address and round index
CNT_W, 16, width of the internal interval timer
TEMPO_ON, 500, clock cycles each entry is lit (>=1, < 2^CNT_W)
TEMPO_OFF, 250, clock cycles of dark gap after each entry (>=1)
PASSO, 25, on-time reduction per round (only with ACELERA_EN)
TEMPO_MIN, 100, lower bound on on-time (only with ACELERA_EN)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
iniciar  input  1  start request, sampled only in OCIOSO
abortar  input  1  cancel playback, return to OCIOSO
rodada  input  ADDR_W  index of last entry to show (inclusive), latched at start
dado_mem  input  4  memory data for current endereco (read result valid in cycle after address change)
endereco  output  ADDR_W  registered memory address
leds  output  4  LED pattern; dado_mem while in ACESO, else 0
mostrando  output  1  high in every state except OCIOSO
fim  output  1  one-cycle pulse when playback completes normally
db_estado  output  4  current state code for hex debug display

Behaviour:
- Reset: state OCIOSO, endereco=0, timer=0, rodada_reg=0, leds=0, mostrando=0, fim=0, db_estado=0.
- States and codes: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, PROXIMO=4, FIM=5. Codes 6–15 are unreachable; if entered, go to OCIOSO.
- OCIOSO: endereco held at 0. If iniciar=1, latch rodada into rodada_reg, clear timer, go to CARREGA.
- CARREGA: exactly 1 cycle for memory read latency; clear timer; go to ACESO.
- ACESO: leds=dado_mem. Timer increments each cycle. After exactly T_on cycles in ACESO, clear timer and go to APAGADO.
- APAGADO: leds=0 for exactly TEMPO_OFF cycles. Then go to FIM if endereco==rodada_reg, else go to PROXIMO.
- PROXIMO: 1 cycle; endereco increments; go to CARREGA.
- FIM: fim=1 for this single cycle; endereco resets to 0; go to OCIOSO.
- Latency (cycles from the iniciar edge to the fim cycle, inclusive): (rodada+1)*(1+T_on+TEMPO_OFF) + rodada + 1.
- abortar=1 in any non-OCIOSO state: next state OCIOSO, endereco=0, no fim pulse. abortar has priority over all transitions; reset has priority over abortar.
- iniciar while mostrando=1 is ignored. Changes on rodada during playback are ignored because rodada_reg is used.
- rodada=0 shows exactly one entry. rodada=2^ADDR_W-1 shows all entries; endereco never wraps during playback.
- Timer compares use CNT_W unsigned arithmetic; timer never exceeds T_on-1 or TEMPO_OFF-1.

Optional Feature:
Macro ACELERA_EN.
- Defined: at the iniciar edge, T_on = max(TEMPO_ON - rodada*PASSO, TEMPO_MIN), computed without underflow. If rodada*PASSO >= TEMPO_ON, T_on = TEMPO_MIN. T_on is held constant for the whole playback.
- Undefined: T_on = TEMPO_ON always; PASSO and TEMPO_MIN are unused.

Test Plan:
1. TEMPO_ON=4, TEMPO_OFF=2, memory {0001,0010,0100}, rodada=2, pulse iniciar -> leds show 0001, 0010, 0100, each for 4 cycles with 2-cycle gaps; fim pulses in the 24th cycle after the iniciar edge; endereco ends at 0.
2. rodada=0, iniciar -> single 0001 flash of 4 cycles; fim pulses in the 8th cycle; mostrando low in the next cycle.
3. Mid-ACESO of entry 1, assert abortar for 1 cycle -> OCIOSO next cycle, leds=0, endereco=0, no fim pulse.
4. During playback, toggle iniciar and change rodada to 5 -> playback unchanged and ends after entry 2; a reset asserted mid-playback -> all outputs 0 on the next cycle.
5. rodada=15 with 16 distinct memory values -> all 16 shown in order, endereco reaches 15 without wrapping, fim pulse once.
6. ACELERA_EN defined, TEMPO_ON=10, PASSO=3, TEMPO_MIN=4: rodada=1 -> each on-interval is 7 cycles; rodada=3 -> each on-interval is 4 cycles (clamped, 10-9=1 below TEMPO_MIN).
